// File: rtl/clue_pkg.sv
// Shared types and constants for the Clue dice-roll and turn logic.
package clue_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    READY  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int DIE_MIN = 1;
  localparam int DIE_MAX = 6;
  localparam int ROLL_W  = 4;

endpackage

// File: rtl/dice_roll_ctrl_if.sv
// Bundle of the dice controller's stimulus inputs and roll/turn outputs.
// Handshake: roll_req is a level request, taken only in IDLE; roll_valid and
// turn_over are single-cycle pulses; move_step/end_turn act only in READY.
interface dice_roll_ctrl_if;
  import clue_pkg::*;

  logic [2:0]        rand_in;
  logic              roll_req;
  logic              move_step;
  logic              end_turn;
  logic [ROLL_W-1:0] die_total;
  logic [ROLL_W-1:0] moves_left;
  logic              roll_valid;
  logic              busy;
  logic              turn_over;
  state_t            state;

  modport master (
    output rand_in, roll_req, move_step, end_turn,
    input  die_total, moves_left, roll_valid, busy, turn_over, state
  );

  modport slave (
    input  rand_in, roll_req, move_step, end_turn,
    output die_total, moves_left, roll_valid, busy, turn_over, state
  );
endinterface

// File: rtl/dice_roll_ctrl_die_filter.sv
// Combinational die-face filter: accepts 1..6 directly; when forced, folds
// 0 to 1 and 7 to 6 so a stuck random source still yields a legal face.
module die_filter
  import clue_pkg::*;
(
  input  logic [2:0] rand_in,
  input  logic       force_accept,
  output logic       accept,
  output logic [2:0] value
);

  logic in_range;

  // Classify the raw sample and pick the face value to add.
  always_comb begin
    in_range = (rand_in >= 3'(DIE_MIN)) && (rand_in <= 3'(DIE_MAX));
    accept   = in_range || force_accept;
    if (in_range) begin
      value = rand_in;
    end else if (rand_in == 3'd0) begin
      value = 3'(DIE_MIN);
    end else begin
      value = 3'(DIE_MAX);
    end
  end

endmodule

// File: rtl/dice_roll_ctrl.sv
// Dice roll controller: rejection-samples the rng stream into NUM_DICE legal
// faces, then tracks moves for the turn until exhausted or forfeited.
module dice_roll_ctrl
  import clue_pkg::*;
#(
  parameter int NUM_DICE  = 2,
  parameter int MAX_TRIES = 4
) (
  input  logic               clk,
  input  logic               reset,
  dice_roll_ctrl_if.slave    bus
);

  localparam logic [2:0] TRY_LAST  = 3'(MAX_TRIES - 1);
  localparam logic [1:0] DICE_LAST = 2'(NUM_DICE);

  state_t            state_q, state_n;
  logic [ROLL_W-1:0] acc_q, acc_n;
  logic [1:0]        dice_q, dice_n;
  logic [2:0]        tries_q, tries_n;
  logic [ROLL_W-1:0] total_q, total_n;
  logic [ROLL_W-1:0] moves_q, moves_n;
  logic              valid_q, valid_n;

  logic              force_accept;
  logic              accept;
  logic [2:0]        value;
  logic [ROLL_W-1:0] sum;

  assign force_accept = (tries_q == TRY_LAST);

  die_filter u_die_filter (
    .rand_in      (bus.rand_in),
    .force_accept (force_accept),
    .accept       (accept),
    .value        (value)
  );

  assign sum = acc_q + {1'b0, value};

  // State and datapath registers; reset discards any roll in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      dice_q  <= '0;
      tries_q <= '0;
      total_q <= '0;
      moves_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_n;
      acc_q   <= acc_n;
      dice_q  <= dice_n;
      tries_q <= tries_n;
      total_q <= total_n;
      moves_q <= moves_n;
      valid_q <= valid_n;
    end
  end

  // Next-state and datapath update for the roll -> move -> turn-over sequence.
  always_comb begin
    state_n = state_q;
    acc_n   = acc_q;
    dice_n  = dice_q;
    tries_n = tries_q;
    total_n = total_q;
    moves_n = moves_q;
    valid_n = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.roll_req) begin
          state_n = SAMPLE;
          acc_n   = '0;
          dice_n  = '0;
          tries_n = '0;
        end
      end
      SAMPLE: begin
        if (accept) begin
          acc_n   = sum;
          dice_n  = dice_q + 2'd1;
          tries_n = '0;
          if (dice_q + 2'd1 == DICE_LAST) begin
            state_n = READY;
            total_n = sum;
            moves_n = sum;
            valid_n = 1'b1;
          end
        end else begin
          tries_n = tries_q + 3'd1;
        end
      end
      READY: begin
        if (bus.end_turn) begin
          moves_n = '0;
          state_n = DONE;
        end else if (bus.move_step) begin
          if (moves_q > 4'd1) begin
            moves_n = moves_q - 4'd1;
          end else begin
            moves_n = '0;
            state_n = DONE;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.die_total  = total_q;
  assign bus.moves_left = moves_q;
  assign bus.roll_valid = valid_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.turn_over  = (state_q == DONE);
  assign bus.state      = state_q;

endmodule

// File: tb/tb_dice_roll_ctrl.sv
// Directed testbench for dice_roll_ctrl with hand-computed expectations.
module tb_dice_roll_ctrl;
  import clue_pkg::*;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;
  logic [2:0] seq [0:15];

  dice_roll_ctrl_if bus ();

  dice_roll_ctrl #(.NUM_DICE(2), .MAX_TRIES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    bus.roll_req  = 1'b0;
    bus.move_step = 1'b0;
    bus.end_turn  = 1'b0;
    bus.rand_in   = 3'd0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_total"}, 32'(bus.die_total), 0);
    check({tag, "_moves"}, 32'(bus.moves_left), 0);
    check({tag, "_valid"}, 32'(bus.roll_valid), 0);
    check({tag, "_busy"},  32'(bus.busy), 0);
    check({tag, "_tover"}, 32'(bus.turn_over), 0);
    check({tag, "_state"}, 32'(bus.state), 32'(IDLE));
  endtask

  // From IDLE: request a roll, feed seq[] one value per edge, and check the
  // roll result and the number of edges from request to roll_valid.
  task automatic do_roll(input string tag, input int n, input int exp_total, input int exp_edges);
    int idx;
    int edges;
    bus.roll_req = 1'b1;
    bus.rand_in  = 3'd0;
    tick();
    bus.roll_req = 1'b0;
    check({tag, "_busy_sample"}, 32'(bus.busy), 1);
    idx   = 0;
    edges = 0;
    while (!bus.roll_valid && edges < 30) begin
      bus.rand_in = seq[(idx < n) ? idx : n - 1];
      idx++;
      tick();
      edges++;
    end
    bus.rand_in = 3'd0;
    check({tag, "_valid"}, 32'(bus.roll_valid), 1);
    check({tag, "_latency"}, 32'(edges), 32'(exp_edges));
    check({tag, "_total"}, 32'(bus.die_total), 32'(exp_total));
    check({tag, "_moves"}, 32'(bus.moves_left), 32'(exp_total));
    check({tag, "_busy"}, 32'(bus.busy), 1);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    do_reset();
    check_zero("reset");

    // Steps and forfeits are ignored in IDLE.
    bus.move_step = 1'b1;
    bus.end_turn  = 1'b1;
    tick();
    bus.move_step = 1'b0;
    bus.end_turn  = 1'b0;
    check("idle_ignore_state", 32'(bus.state), 32'(IDLE));

    // 1: legal faces 3 then 5.
    seq[0] = 3'd3; seq[1] = 3'd5;
    do_roll("t1", 2, 8, 2);
    tick();
    check("t1_valid_once", 32'(bus.roll_valid), 0);
    do_reset();

    // 2: two rejects then 4, 2.
    seq[0] = 3'd0; seq[1] = 3'd7; seq[2] = 3'd4; seq[3] = 3'd2;
    do_roll("t2", 4, 6, 4);
    do_reset();

    // 3: stuck at 7, each die forced to 6 on its 4th sample.
    for (int i = 0; i < 8; i++) seq[i] = 3'd7;
    do_roll("t3", 8, 12, 8);
    do_reset();

    // 4: three steps from 3 moves.
    seq[0] = 3'd1; seq[1] = 3'd2;
    do_roll("t4", 2, 3, 2);
    bus.move_step = 1'b1;
    tick();
    check("t4_step1", 32'(bus.moves_left), 2);
    tick();
    check("t4_step2", 32'(bus.moves_left), 1);
    check("t4_tover_early", 32'(bus.turn_over), 0);
    tick();
    bus.move_step = 1'b0;
    check("t4_step3", 32'(bus.moves_left), 0);
    check("t4_tover", 32'(bus.turn_over), 1);
    check("t4_state_done", 32'(bus.state), 32'(DONE));
    tick();
    check("t4_tover_end", 32'(bus.turn_over), 0);
    check("t4_busy", 32'(bus.busy), 0);
    check("t4_state_idle", 32'(bus.state), 32'(IDLE));
    check("t4_total_kept", 32'(bus.die_total), 3);

    // 5: end_turn beats move_step; roll_req ignored in READY, then level restart.
    seq[0] = 3'd2; seq[1] = 3'd3;
    do_roll("t5", 2, 5, 2);
    bus.roll_req = 1'b1;
    tick();
    check("t5_ready_hold", 32'(bus.moves_left), 5);
    check("t5_ready_state", 32'(bus.state), 32'(READY));
    bus.move_step = 1'b1;
    bus.end_turn  = 1'b1;
    tick();
    bus.move_step = 1'b0;
    bus.end_turn  = 1'b0;
    check("t5_moves", 32'(bus.moves_left), 0);
    check("t5_tover", 32'(bus.turn_over), 1);
    check("t5_total", 32'(bus.die_total), 5);
    tick();
    check("t5_tover_end", 32'(bus.turn_over), 0);
    check("t5_idle", 32'(bus.state), 32'(IDLE));
    tick();
    bus.roll_req = 1'b0;
    check("t5_level_restart", 32'(bus.state), 32'(SAMPLE));

    // 6: reset mid-SAMPLE after one accepted die.
    do_reset();
    bus.roll_req = 1'b1;
    tick();
    bus.roll_req = 1'b0;
    bus.rand_in  = 3'd4;
    tick();
    check("t6_one_die", 32'(bus.state), 32'(SAMPLE));
    reset       = 1'b1;
    bus.rand_in = 3'd5;
    tick();
    reset = 1'b0;
    check_zero("t6_rst_sample");

    // Reset during READY.
    seq[0] = 3'd6; seq[1] = 3'd6;
    do_roll("t6a", 2, 12, 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_zero("t6_rst_ready");
    seq[0] = 3'd1; seq[1] = 3'd1;
    do_roll("t6b", 2, 2, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
